msdap_out_serializer: RTL

Parametrised multi-channel output serializer for the MSDAP datapath, clocked on Sclk.
- Accepts one parallel result word per channel from the filter core and buffers it in a small FIFO.
- Shifts each buffered word out on one serial pin per channel, LSB first, with OutReady high for exactly W Sclk cycles per word.
- Generalises the fixed stereo 40-bit output stage to NCH channels, width W and FIFO depth DEPTH.
- Adds a configurable inter-word gap, overflow detection and flush.

---
 rtl/msdap_out_serializer.sv | 117 +++++++++++
 1 files changed

// File: rtl/msdap_out_serializer.sv
// msdap_out_serializer: NCH-channel FIFO-buffered serializer, LSB first by default
// (MSB first when MSDAP_OSER_MSB_FIRST_EN is defined), with inter-word gap, overflow and flush.
module msdap_out_serializer #(
  parameter int NCH   = 2,
  parameter int W     = 40,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                         Sclk,
  input  logic                         Reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NCH*W-1:0]             in_data,
  input  logic                         Flush,
  output logic                         OutReady,
  output logic [NCH-1:0]               Output,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(W);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
`ifdef MSDAP_OSER_MSB_FIRST_EN
  localparam int OB = W - 1;
`else
  localparam int OB = 0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [NCH*W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic [CW-1:0]    r_bcnt;
  logic [GW-1:0]    r_gcnt;
  logic [W-1:0]     r_sh [NCH];
  logic             w_push, w_pop;
  logic [NCH*W-1:0] w_head;

  assign in_ready = r_level < LW'(DEPTH);
  assign level    = r_level;
  assign overflow = r_ovf;
  assign OutReady = r_state == ST_SHIFT;
  assign w_push   = in_valid & in_ready & ~Flush;
  assign w_head   = r_mem[r_rp];

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_out
      assign Output[c] = OutReady & r_sh[c][OB];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_level != '0) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_SHIFT;
                end
      ST_SHIFT: if (r_bcnt == CW'(W-1)) w_state_nxt = ST_GAP;
      ST_GAP:   if (r_gcnt == GW'(GAP-1)) begin
                  w_pop       = r_level != '0;
                  w_state_nxt = r_level != '0 ? ST_SHIFT : ST_IDLE;
                end
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (Flush) begin
      w_state_nxt = ST_IDLE;
      w_pop       = 1'b0;
    end
  end

  always_ff @(posedge Sclk or negedge Reset_n)
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;

  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge Sclk)
    if (w_push) r_mem[r_wp] <= in_data;

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
      for (int i = 0; i < NCH; i++) r_sh[i] <= '0;
    end else begin
      if (Flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_level <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop)  r_rp <= r_rp + AW'(1);
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
        if (in_valid && !in_ready) r_ovf <= 1'b1;
      end
      r_bcnt <= w_pop ? '0 : (r_state == ST_SHIFT ? r_bcnt + CW'(1) : r_bcnt);
      r_gcnt <= r_state == ST_SHIFT ? '0 : (r_state == ST_GAP ? r_gcnt + GW'(1) : r_gcnt);
      for (int i = 0; i < NCH; i++)
`ifdef MSDAP_OSER_MSB_FIRST_EN
        r_sh[i] <= w_pop ? w_head[i*W +: W] : r_sh[i] << 1;
`else
        r_sh[i] <= w_pop ? w_head[i*W +: W] : r_sh[i] >> 1;
`endif
    end
  end
endmodule
